// File: rtl/bus_arbiter_if.sv
// Bus signals of the PET memory-bus slot arbiter.
// The master side (CPU glue / SPI bridge / video timing) drives the requests
// and the run enable; the slave side (the arbiter) drives grants, acks,
// phi2 and slot timing.
//
// Handshake: a requester holds its req level high; the arbiter grants whole
// slots only, pulses ack for one clock on the last clock of each granted
// slot, and treats a request still high at the next slot boundary as a new
// transaction. There is no back-pressure from the arbiter side.
interface bus_arbiter_if;
    logic        cpu_en_i;
    logic        spi_req_i;
    logic        video_req_i;
    logic        cpu_clk_o;
    logic        cpu_grant_o;
    logic        spi_grant_o;
    logic        video_grant_o;
    logic        spi_ack_o;
    logic        video_ack_o;
    logic        cycle_start_o;
    logic [1:0]  slot_o;
    logic [15:0] spi_wait_count_o;

    modport slave (
        input  cpu_en_i, spi_req_i, video_req_i,
        output cpu_clk_o, cpu_grant_o, spi_grant_o, video_grant_o,
               spi_ack_o, video_ack_o, cycle_start_o, slot_o, spi_wait_count_o
    );

    modport master (
        output cpu_en_i, spi_req_i, video_req_i,
        input  cpu_clk_o, cpu_grant_o, spi_grant_o, video_grant_o,
               spi_ack_o, video_ack_o, cycle_start_o, slot_o, spi_wait_count_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Time-slot scheduler for the shared PET memory bus (BRAM + external RAM/IO).
// Each CPU cycle of CLK_MHZ system clocks is split into four equal slots.
// Slot owners are chosen at each slot boundary and held for the whole slot:
//   slot 0     : video, else SPI, else idle
//   slots 1, 2 : SPI, else video, else idle
//   slot 3     : CPU (if running), else SPI, else idle
// CPU phi2 is high for the second half of the cycle while the CPU runs.
// CLK_MHZ must be a multiple of 4 and at least 8.
//
// Optional feature: define BUS_ARB_STATS_EN to build the saturating 16-bit
// SPI wait counter; otherwise spi_wait_count_o reads zero.
//
// All outputs are registered. The position inside the cycle is kept as a
// slot index plus a within-slot counter so no divider is needed when
// SLOT_CLKS is not a power of two.
module bus_arbiter #(
    parameter  int CLK_MHZ   = 64,
    localparam int SLOT_CLKS = CLK_MHZ / 4
) (
    input  logic          clk_sys_i,
    input  logic          reset_n_i,
    bus_arbiter_if.slave  bus
);

    localparam int            SW       = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
    localparam logic [SW-1:0] SUB_LAST = SW'(SLOT_CLKS - 1);

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_SPI   = 2'd2,
        OWN_VIDEO = 2'd3
    } owner_t;

    // started_q stays low for the first clock after reset release so that
    // the first edge lands on cnt 0 with cycle_start asserted.
    logic          started_q,     started_d;
    logic [SW-1:0] sub_q,         sub_d;
    logic [1:0]    slot_q,        slot_d;
    logic          cpu_run_q,     cpu_run_d;
    owner_t        owner_q,       owner_d;
    logic          cpu_grant_q,   cpu_grant_d;
    logic          spi_grant_q,   spi_grant_d;
    logic          video_grant_q, video_grant_d;
    logic          spi_ack_q,     spi_ack_d;
    logic          video_ack_q,   video_ack_d;
    logic          cycle_start_q, cycle_start_d;
    logic          cpu_clk_q,     cpu_clk_d;
    logic          boundary;

    // Next cycle position, slot ownership and registered output values
    always_comb begin
        started_d     = 1'b1;
        sub_d         = sub_q;
        slot_d        = slot_q;
        cpu_run_d     = cpu_run_q;
        owner_d       = owner_q;
        boundary      = (!started_q) || (sub_q == SUB_LAST);

        if (!started_q) begin
            sub_d  = '0;
            slot_d = 2'd0;
        end else if (sub_q == SUB_LAST) begin
            sub_d  = '0;
            slot_d = slot_q + 2'd1;
        end else begin
            sub_d  = sub_q + SW'(1);
        end

        // The run enable is only taken at the start of a CPU cycle so a
        // phi2 pulse or CPU slot is never cut short.
        if (boundary && (slot_d == 2'd0)) begin
            cpu_run_d = bus.cpu_en_i;
        end

        if (boundary) begin
            case (slot_d)
                2'd0: begin
                    if (bus.video_req_i)    owner_d = OWN_VIDEO;
                    else if (bus.spi_req_i) owner_d = OWN_SPI;
                    else                    owner_d = OWN_IDLE;
                end
                2'd3: begin
                    if (cpu_run_d)          owner_d = OWN_CPU;
                    else if (bus.spi_req_i) owner_d = OWN_SPI;
                    else                    owner_d = OWN_IDLE;
                end
                default: begin
                    if (bus.spi_req_i)        owner_d = OWN_SPI;
                    else if (bus.video_req_i) owner_d = OWN_VIDEO;
                    else                      owner_d = OWN_IDLE;
                end
            endcase
        end

        cpu_grant_d   = (owner_d == OWN_CPU);
        spi_grant_d   = (owner_d == OWN_SPI);
        video_grant_d = (owner_d == OWN_VIDEO);
        spi_ack_d     = (owner_d == OWN_SPI)   && (sub_d == SUB_LAST);
        video_ack_d   = (owner_d == OWN_VIDEO) && (sub_d == SUB_LAST);
        cycle_start_d = boundary && (slot_d == 2'd0);
        cpu_clk_d     = cpu_run_d && slot_d[1];
    end

    // State and output registers; reset drops grants and acks immediately
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            started_q     <= 1'b0;
            sub_q         <= '0;
            slot_q        <= 2'd0;
            cpu_run_q     <= 1'b0;
            owner_q       <= OWN_IDLE;
            cpu_grant_q   <= 1'b0;
            spi_grant_q   <= 1'b0;
            video_grant_q <= 1'b0;
            spi_ack_q     <= 1'b0;
            video_ack_q   <= 1'b0;
            cycle_start_q <= 1'b0;
            cpu_clk_q     <= 1'b0;
        end else begin
            started_q     <= started_d;
            sub_q         <= sub_d;
            slot_q        <= slot_d;
            cpu_run_q     <= cpu_run_d;
            owner_q       <= owner_d;
            cpu_grant_q   <= cpu_grant_d;
            spi_grant_q   <= spi_grant_d;
            video_grant_q <= video_grant_d;
            spi_ack_q     <= spi_ack_d;
            video_ack_q   <= video_ack_d;
            cycle_start_q <= cycle_start_d;
            cpu_clk_q     <= cpu_clk_d;
        end
    end

    assign bus.cpu_grant_o   = cpu_grant_q;
    assign bus.spi_grant_o   = spi_grant_q;
    assign bus.video_grant_o = video_grant_q;
    assign bus.spi_ack_o     = spi_ack_q;
    assign bus.video_ack_o   = video_ack_q;
    assign bus.cycle_start_o = cycle_start_q;
    assign bus.cpu_clk_o     = cpu_clk_q;
    assign bus.slot_o        = slot_q;

`ifdef BUS_ARB_STATS_EN
    logic [15:0] spi_wait_q, spi_wait_d;

    // Count clocks where SPI is asking but does not hold the bus, saturating
    always_comb begin
        spi_wait_d = spi_wait_q;
        if (bus.spi_req_i && !spi_grant_q && (spi_wait_q != 16'hFFFF)) begin
            spi_wait_d = spi_wait_q + 16'd1;
        end
    end

    // Wait counter register, cleared only by reset
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            spi_wait_q <= 16'd0;
        end else begin
            spi_wait_q <= spi_wait_d;
        end
    end

    assign bus.spi_wait_count_o = spi_wait_q;
`else
    assign bus.spi_wait_count_o = 16'd0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter at CLK_MHZ = 64 (16 clocks per slot).
// Slot owners for each cycle are written by hand as a 4-entry vector.
module tb_bus_arbiter;

    localparam logic [1:0] O_I = 2'd0;
    localparam logic [1:0] O_C = 2'd1;
    localparam logic [1:0] O_S = 2'd2;
    localparam logic [1:0] O_V = 2'd3;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bus_arbiter_if bus ();

    bus_arbiter #(.CLK_MHZ(64)) dut (
        .clk_sys_i (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic spi, input logic vid);
        bus.cpu_en_i    = en;
        bus.spi_req_i   = spi;
        bus.video_req_i = vid;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " cpu_grant"},   16'(bus.cpu_grant_o),   16'd0);
        check({tag, " spi_grant"},   16'(bus.spi_grant_o),   16'd0);
        check({tag, " video_grant"}, 16'(bus.video_grant_o), 16'd0);
        check({tag, " spi_ack"},     16'(bus.spi_ack_o),     16'd0);
        check({tag, " video_ack"},   16'(bus.video_ack_o),   16'd0);
        check({tag, " cycle_start"}, 16'(bus.cycle_start_o), 16'd0);
        check({tag, " cpu_clk"},     16'(bus.cpu_clk_o),     16'd0);
        check({tag, " slot"},        16'(bus.slot_o),        16'd0);
    endtask

    // Hold reset for a few clocks, check the reset state, release, and
    // advance to the first clock of the first cycle (cnt 0).
    task automatic do_reset(input logic en, input logic spi, input logic vid);
        rst_n = 1'b0;
        drive(en, spi, vid);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset spi_wait", bus.spi_wait_count_o, 16'd0);
        rst_n = 1'b1;
        tick();
    endtask

    // Check one full CPU cycle starting at cnt 0. owners = {slot3,slot2,slot1,slot0}.
    // Inputs are changed at the falling edge of cnt == chg_at (after checks).
    task automatic run_cycle(input string name, input logic [7:0] owners, input logic phi2,
                             input int chg_at, input logic n_en, input logic n_spi,
                             input logic n_vid);
        for (int c = 0; c < 64; c++) begin
            logic [1:0] own;
            string      t;
            own = owners[2*(c/16) +: 2];
            t   = $sformatf("%s cnt=%0d", name, c);
            check({t, " slot"},        16'(bus.slot_o),        16'(c / 16));
            check({t, " cycle_start"}, 16'(bus.cycle_start_o), 16'(c == 0));
            check({t, " cpu_grant"},   16'(bus.cpu_grant_o),   16'(own == O_C));
            check({t, " spi_grant"},   16'(bus.spi_grant_o),   16'(own == O_S));
            check({t, " video_grant"}, 16'(bus.video_grant_o), 16'(own == O_V));
            check({t, " spi_ack"},     16'(bus.spi_ack_o),     16'((own == O_S) && (c % 16 == 15)));
            check({t, " video_ack"},   16'(bus.video_ack_o),   16'((own == O_V) && (c % 16 == 15)));
            check({t, " cpu_clk"},     16'(bus.cpu_clk_o),     16'(phi2 && (c >= 32)));
            if (c == chg_at) drive(n_en, n_spi, n_vid);
            tick();
        end
    endtask

    // Directed sequence
    initial begin
        logic [15:0] exp_wait;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        drive(1'b0, 1'b0, 1'b0);

        // Idle bus with CPU enabled: CPU owns slot 3, phi2 high for cnt 32..63
        do_reset(1'b1, 1'b0, 1'b0);
        run_cycle("idle0", {O_C, O_I, O_I, O_I}, 1'b1, -1, 1'b1, 1'b0, 1'b0);
        run_cycle("idle1", {O_C, O_I, O_I, O_I}, 1'b1, 63, 1'b1, 1'b1, 1'b0);

        // SPI only: slots 0..2 to SPI with acks at 15/31/47, slot 3 to CPU
        run_cycle("spi0", {O_C, O_S, O_S, O_S}, 1'b1, -1, 1'b1, 1'b1, 1'b0);
        run_cycle("spi1", {O_C, O_S, O_S, O_S}, 1'b1, 63, 1'b1, 1'b1, 1'b1);

        // Both requesting; CPU enable drops at cnt 40 mid-phi2
        run_cycle("both_endrop", {O_C, O_S, O_S, O_V}, 1'b1, 40, 1'b0, 1'b1, 1'b1);
        // CPU stopped: phi2 low, slot 3 falls to SPI; video drops at end
        run_cycle("cpu_off", {O_S, O_S, O_S, O_V}, 1'b0, 63, 1'b0, 1'b1, 1'b0);
        run_cycle("spi_all", {O_S, O_S, O_S, O_S}, 1'b0, -1, 1'b0, 1'b1, 1'b0);

        // Reset at cnt 20 during an SPI grant: grant falls with no clock edge
        repeat (20) tick();
        check("pre_rst spi_grant", 16'(bus.spi_grant_o), 16'd1);
        check("pre_rst slot",      16'(bus.slot_o),      16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        repeat (2) begin
            tick();
            check("in_rst spi_ack",   16'(bus.spi_ack_o),   16'd0);
            check("in_rst spi_grant", 16'(bus.spi_grant_o), 16'd0);
        end
        rst_n = 1'b1;
        tick();
        run_cycle("after_rst", {O_S, O_S, O_S, O_S}, 1'b0, -1, 1'b0, 1'b1, 1'b0);

        // SPI wait statistic: both requesting, CPU on, ten cycles
        do_reset(1'b1, 1'b0, 1'b0);
        run_cycle("stat0", {O_C, O_S, O_S, O_I}, 1'b1, 0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k < 10; k++) begin
            run_cycle($sformatf("stat%0d", k), {O_C, O_S, O_S, O_V}, 1'b1, -1,
                      1'b1, 1'b1, 1'b1);
        end
`ifdef BUS_ARB_STATS_EN
        exp_wait = 16'd320;
`else
        exp_wait = 16'd0;
`endif
        check("spi_wait_count", bus.spi_wait_count_o, exp_wait);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
